// File: rtl/rd_alu_mdu_top.sv
// EX-stage execution unit: single-cycle ALU with flags plus an iterative
// RV M-extension multiply/divide unit behind a valid/ready handshake.
module rd_alu_mdu_top #(
  parameter int XLEN    = 64,
  parameter bit MEXT_EN = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] A_i,
  input  logic [XLEN-1:0] B_i,
  input  logic [3:0]      instruction_i,
  input  logic [1:0]      ALUop_i,
  input  logic            mext_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] C_o,
  output logic            zero_o,
  output logic            carry_o,
  output logic            overflow_o,
  output logic            negative_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0]   ONE   = {{(XLEN-1){1'b0}}, 1'b1};
  localparam logic [2*XLEN-1:0] ONE2  = {{(2*XLEN-1){1'b0}}, 1'b1};
  localparam logic [XLEN-1:0]   ONES  = {XLEN{1'b1}};
  localparam logic [XLEN-1:0]   ZEROS = {XLEN{1'b0}};
  localparam logic [XLEN-1:0]   SMIN  = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_PASSB, OP_AND, OP_OR, OP_XOR,
    OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU
  } alu_op_t;

  state_t            state_r, state_nxt_s;
  alu_op_t           alu_op_s;
  logic              accept_s, is_mdu_s, is_div_s, special_s;
  logic              div_zero_s, div_ovf_s;
  logic              a_signed_s, b_signed_s, a_neg_s, b_neg_s, res_neg_s;
  logic [2:0]        funct3_s;
  logic [SHW-1:0]    shamt_s;
  logic [XLEN:0]     sum_s, dif_s;
  logic [XLEN-1:0]   a_mag_s, b_mag_s, spec_res_s;
  logic [XLEN-1:0]   alu_res_s, acc_res_s;
  logic              alu_carry_s, alu_ovf_s, acc_carry_s, acc_ovf_s;
  logic [XLEN:0]     mul_sum_s, trial_s;
  logic [XLEN-1:0]   hi_step_s, lo_step_s;
  logic [2*XLEN-1:0] prod_s, prod_sel_s;
  logic [XLEN-1:0]   quo_s, rem_s, fix_res_s;

  logic [XLEN-1:0]   hi_r, lo_r, mag_r, c_r;
  logic [CW-1:0]     cnt_r;
  logic [2:0]        op_r;
  logic              neg_r, valid_r, zero_r, carry_r, ovf_r, neg_flag_r;

  assign funct3_s = instruction_i[2:0];
  assign shamt_s  = B_i[SHW-1:0];
  assign is_mdu_s = MEXT_EN && (ALUop_i == 2'b10) && mext_i;
  assign is_div_s = funct3_s[2];
  assign ready_o  = (state_r != CALC) && (!valid_r || ready_i);
  assign accept_s = valid_i && ready_o;

  assign valid_o    = valid_r;
  assign C_o        = c_r;
  assign zero_o     = zero_r;
  assign carry_o    = carry_r;
  assign overflow_o = ovf_r;
  assign negative_o = neg_flag_r;

  // ALU operation decode from the main-decoder class and {funct7[5], funct3}
  always_comb begin
    alu_op_s = OP_ADD;
    case (ALUop_i)
      2'b00: alu_op_s = OP_ADD;
      2'b01: alu_op_s = OP_SUB;
      2'b11: alu_op_s = OP_PASSB;
      2'b10: begin
        case (instruction_i)
          4'b0000: alu_op_s = OP_ADD;
          4'b1000: alu_op_s = OP_SUB;
          4'b0111: alu_op_s = OP_AND;
          4'b0110: alu_op_s = OP_OR;
          4'b0100: alu_op_s = OP_XOR;
          4'b0001: alu_op_s = OP_SLL;
          4'b0101: alu_op_s = OP_SRL;
          4'b1101: alu_op_s = OP_SRA;
          4'b0010: alu_op_s = OP_SLT;
          4'b0011: alu_op_s = OP_SLTU;
          default: alu_op_s = OP_ADD;
        endcase
      end
      default: alu_op_s = OP_ADD;
    endcase
  end

  assign sum_s = {1'b0, A_i} + {1'b0, B_i};
  assign dif_s = {1'b0, A_i} + {1'b0, ~B_i} + {{XLEN{1'b0}}, 1'b1};

  // Single-cycle ALU; subtract carry is the raw carry-out of A + ~B + 1
  always_comb begin
    alu_res_s   = sum_s[XLEN-1:0];
    alu_carry_s = 1'b0;
    alu_ovf_s   = 1'b0;
    case (alu_op_s)
      OP_ADD: begin
        alu_res_s   = sum_s[XLEN-1:0];
        alu_carry_s = sum_s[XLEN];
        alu_ovf_s   = (A_i[XLEN-1] == B_i[XLEN-1]) && (sum_s[XLEN-1] != A_i[XLEN-1]);
      end
      OP_SUB: begin
        alu_res_s   = dif_s[XLEN-1:0];
        alu_carry_s = dif_s[XLEN];
        alu_ovf_s   = (A_i[XLEN-1] != B_i[XLEN-1]) && (dif_s[XLEN-1] != A_i[XLEN-1]);
      end
      OP_PASSB: alu_res_s = B_i;
      OP_AND:   alu_res_s = A_i & B_i;
      OP_OR:    alu_res_s = A_i | B_i;
      OP_XOR:   alu_res_s = A_i ^ B_i;
      OP_SLL:   alu_res_s = A_i << shamt_s;
      OP_SRL:   alu_res_s = A_i >> shamt_s;
      OP_SRA:   alu_res_s = $unsigned($signed(A_i) >>> shamt_s);
      OP_SLT:   alu_res_s = {{(XLEN-1){1'b0}}, ($signed(A_i) < $signed(B_i))};
      OP_SLTU:  alu_res_s = {{(XLEN-1){1'b0}}, (A_i < B_i)};
      default:  alu_res_s = sum_s[XLEN-1:0];
    endcase
  end

  // Operand signedness, magnitudes, result sign and divide special cases
  always_comb begin
    a_signed_s = (funct3_s == 3'b000) || (funct3_s == 3'b001) || (funct3_s == 3'b010)
              || (funct3_s == 3'b100) || (funct3_s == 3'b110);
    b_signed_s = (funct3_s == 3'b000) || (funct3_s == 3'b001)
              || (funct3_s == 3'b100) || (funct3_s == 3'b110);
    a_neg_s    = a_signed_s && A_i[XLEN-1];
    b_neg_s    = b_signed_s && B_i[XLEN-1];
    a_mag_s    = a_neg_s ? (~A_i + ONE) : A_i;
    b_mag_s    = b_neg_s ? (~B_i + ONE) : B_i;
    if (is_div_s && funct3_s[1]) begin
      res_neg_s = a_neg_s;
    end else begin
      res_neg_s = a_neg_s ^ b_neg_s;
    end
    div_zero_s = is_div_s && (B_i == ZEROS);
    div_ovf_s  = is_div_s && !funct3_s[0] && (A_i == SMIN) && (B_i == ONES);
    special_s  = is_mdu_s && (div_zero_s || div_ovf_s);
    if (div_zero_s) begin
      spec_res_s = funct3_s[1] ? A_i : ONES;
    end else begin
      spec_res_s = funct3_s[1] ? ZEROS : A_i;
    end
  end

  // Result registered on the accept edge (ALU ops and divide special cases)
  always_comb begin
    if (is_mdu_s) begin
      acc_res_s   = spec_res_s;
      acc_carry_s = 1'b0;
      acc_ovf_s   = 1'b0;
    end else begin
      acc_res_s   = alu_res_s;
      acc_carry_s = alu_carry_s;
      acc_ovf_s   = alu_ovf_s;
    end
  end

  // One MDU iteration: shift-add multiply or restoring divide step
  always_comb begin
    mul_sum_s = {1'b0, hi_r} + (lo_r[0] ? {1'b0, mag_r} : {(XLEN+1){1'b0}});
    trial_s   = {hi_r, lo_r[XLEN-1]} - {1'b0, mag_r};
    if (op_r[2]) begin
      if (!trial_s[XLEN]) begin
        hi_step_s = trial_s[XLEN-1:0];
        lo_step_s = {lo_r[XLEN-2:0], 1'b1};
      end else begin
        hi_step_s = {hi_r[XLEN-2:0], lo_r[XLEN-1]};
        lo_step_s = {lo_r[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_step_s = mul_sum_s[XLEN:1];
      lo_step_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
    end
  end

  // Sign fixup and result selection once all iterations are done
  always_comb begin
    prod_s     = {hi_r, lo_r};
    prod_sel_s = neg_r ? (~prod_s + ONE2) : prod_s;
    quo_s      = neg_r ? (~lo_r + ONE) : lo_r;
    rem_s      = neg_r ? (~hi_r + ONE) : hi_r;
    case (op_r)
      3'b000:                 fix_res_s = prod_sel_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res_s = prod_sel_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res_s = quo_s;
      3'b110, 3'b111:         fix_res_s = rem_s;
      default:                fix_res_s = prod_sel_s[XLEN-1:0];
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state; an accept in DONE doubles as consumption of the old result
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          state_nxt_s = (is_mdu_s && !special_s) ? CALC : DONE;
        end else if (state_r == DONE && ready_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      CALC: begin
        if (cnt_r == {CW{1'b0}}) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = CALC;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration registers and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_r    <= 1'b0;
      c_r        <= ZEROS;
      zero_r     <= 1'b0;
      carry_r    <= 1'b0;
      ovf_r      <= 1'b0;
      neg_flag_r <= 1'b0;
      hi_r       <= ZEROS;
      lo_r       <= ZEROS;
      mag_r      <= ZEROS;
      cnt_r      <= {CW{1'b0}};
      op_r       <= 3'b000;
      neg_r      <= 1'b0;
    end else begin
      valid_r <= (state_nxt_s == DONE);
      if (accept_s) begin
        if (is_mdu_s && !special_s) begin
          hi_r  <= ZEROS;
          lo_r  <= is_div_s ? a_mag_s : b_mag_s;
          mag_r <= is_div_s ? b_mag_s : a_mag_s;
          cnt_r <= CW'(XLEN);
          op_r  <= funct3_s;
          neg_r <= res_neg_s;
        end else begin
          c_r        <= acc_res_s;
          zero_r     <= (acc_res_s == ZEROS);
          carry_r    <= acc_carry_s;
          ovf_r      <= acc_ovf_s;
          neg_flag_r <= acc_res_s[XLEN-1];
        end
      end else if (state_r == CALC) begin
        if (cnt_r != {CW{1'b0}}) begin
          hi_r  <= hi_step_s;
          lo_r  <= lo_step_s;
          cnt_r <= cnt_r - CW'(1);
        end else begin
          c_r        <= fix_res_s;
          zero_r     <= (fix_res_s == ZEROS);
          carry_r    <= 1'b0;
          ovf_r      <= 1'b0;
          neg_flag_r <= fix_res_s[XLEN-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_rd_alu_mdu_top.sv
// Scoreboard bench for rd_alu_mdu_top (XLEN=64): the driver queues expected
// results on accept, a negedge monitor checks latency, hold stability and values.
module tb_rd_alu_mdu_top;
  localparam int XLEN = 64;
  localparam int MDU_EDGES = XLEN + 1;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [XLEN-1:0] A_i = '0;
  logic [XLEN-1:0] B_i = '0;
  logic [3:0]      instruction_i = 4'd0;
  logic [1:0]      ALUop_i = 2'd0;
  logic            mext_i = 1'b0;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [XLEN-1:0] C_o;
  logic            zero_o, carry_o, overflow_o, negative_o;

  rd_alu_mdu_top #(.XLEN(XLEN), .MEXT_EN(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .ready_o(ready_o),
    .A_i(A_i), .B_i(B_i), .instruction_i(instruction_i), .ALUop_i(ALUop_i),
    .mext_i(mext_i), .valid_o(valid_o), .ready_i(ready_i), .C_o(C_o),
    .zero_o(zero_o), .carry_o(carry_o), .overflow_o(overflow_o),
    .negative_o(negative_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // flags packed as {zero, carry, overflow, negative}
  typedef struct {
    string           name;
    logic [XLEN-1:0] c;
    logic [3:0]      fl;
    int              edges;
    int              acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   last_acc = 0;

  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  task automatic check(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Issue one request; returns at posedge+1 of the accept edge.
  task automatic issue(input string nm, input logic [1:0] aop, input logic mx,
                       input logic [3:0] ins, input logic [XLEN-1:0] a,
                       input logic [XLEN-1:0] b, input logic [XLEN-1:0] c,
                       input logic [3:0] fl, input int edges);
    bit ok;
    ok = 1'b0;
    ALUop_i = aop; mext_i = mx; instruction_i = ins; A_i = a; B_i = b;
    valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (ready_o) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL accept_timeout %s: ready_o stayed low for 200 cycles, expected high", nm);
      valid_i = 1'b0;
      @(posedge clk_i); #1;
      return;
    end
    @(posedge clk_i); #1;
    last_acc = cyc;
    sb.push_back('{nm, c, fl, edges, cyc});
    valid_i = 1'b0;
    A_i = ~a;
    B_i = ~b;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i); #1;
      if (sb.size() == 0) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL result_timeout: %0d results still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: checks latency on first sight, stability while stalled, values on handshake
  initial begin
    bit              seen;
    logic [XLEN-1:0] held_c;
    logic [3:0]      held_f;
    exp_t            e;
    seen = 1'b0;
    held_c = '0;
    held_f = 4'd0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        seen = 1'b0;
      end else if (valid_o) begin
        if (sb.size() == 0) begin
          n_chk++;
          $display("FAIL stray_result: got C_o=%h with nothing outstanding, expected valid_o=0", C_o);
        end else begin
          e = sb[0];
          if (!seen) begin
            check({e.name, "_edges"}, 64'(cyc - e.acc), 64'(e.edges));
            seen = 1'b1;
            held_c = C_o;
            held_f = {zero_o, carry_o, overflow_o, negative_o};
          end else begin
            check({e.name, "_hold_c"}, C_o, held_c);
            check({e.name, "_hold_flags"}, 64'({zero_o, carry_o, overflow_o, negative_o}), 64'(held_f));
          end
          if (ready_i) begin
            check({e.name, "_c"}, C_o, e.c);
            check({e.name, "_flags"}, 64'({zero_o, carry_o, overflow_o, negative_o}), 64'(e.fl));
            void'(sb.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected finish");
    $fatal(1);
  end

  initial begin
    int  acc0;
    bit  bad;

    #12;
    check("reset_valid", 64'(valid_o), 64'd0);
    check("reset_c", C_o, 64'd0);
    check("reset_flags", 64'({zero_o, carry_o, overflow_o, negative_o}), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("ready_after_reset", 64'(ready_o), 64'd1);
    @(posedge clk_i); #1;

    // ALU vectors
    issue("add_zero",  2'b00, 1'b0, 4'b0000, 64'd5, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 4'b1100, 0);
    issue("add_ovf",   2'b00, 1'b0, 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, SMIN, 4'b0011, 0);
    issue("sub_neg",   2'b01, 1'b0, 4'b0000, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001, 0);
    issue("sub_eq",    2'b01, 1'b0, 4'b0000, 64'd9, 64'd9, 64'd0, 4'b1100, 0);
    issue("xor",       2'b10, 1'b0, 4'b0100, 64'hFF00, 64'h0FF0, 64'hF0F0, 4'b0000, 0);
    issue("and",       2'b10, 1'b0, 4'b0111, 64'hFF00, 64'h0FF0, 64'h0F00, 4'b0000, 0);
    issue("or",        2'b10, 1'b0, 4'b0110, 64'hFF00, 64'h0FF0, 64'hFFF0, 4'b0000, 0);
    issue("sll_mask",  2'b10, 1'b0, 4'b0001, 64'd1, 64'h43, 64'd8, 4'b0000, 0);
    issue("srl",       2'b10, 1'b0, 4'b0101, SMIN, 64'd4, 64'h0800_0000_0000_0000, 4'b0000, 0);
    issue("sra",       2'b10, 1'b0, 4'b1101, SMIN, 64'd4, 64'hF800_0000_0000_0000, 4'b0001, 0);
    issue("slt",       2'b10, 1'b0, 4'b0010, ONES, 64'd1, 64'd1, 4'b0000, 0);
    issue("sltu",      2'b10, 1'b0, 4'b0011, ONES, 64'd1, 64'd0, 4'b1000, 0);
    issue("pass_b",    2'b11, 1'b0, 4'b0000, 64'd99, 64'h1234, 64'h1234, 4'b0000, 0);
    issue("undef_add", 2'b10, 1'b0, 4'b1111, 64'd2, 64'd3, 64'd5, 4'b0000, 0);
    wait_idle();

    // MUL: ready_o must stay low through all CALC cycles
    issue("mul", 2'b10, 1'b1, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7,
          64'hFFFF_FFFF_FFFF_FFEB, 4'b0001, MDU_EDGES);
    bad = 1'b0;
    for (int i = 0; i < XLEN; i++) begin
      @(negedge clk_i);
      if (ready_o || valid_o) bad = 1'b1;
    end
    check("mul_busy_in_calc", 64'(bad), 64'd0);
    wait_idle();

    issue("mulhu",  2'b10, 1'b1, 4'b0011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0001, MDU_EDGES);
    issue("mulh",   2'b10, 1'b1, 4'b0001, ONES, ONES, 64'd0, 4'b1000, MDU_EDGES);
    issue("mulhsu", 2'b10, 1'b1, 4'b0010, ONES, 64'd2, ONES, 4'b0001, MDU_EDGES);
    issue("div",    2'b10, 1'b1, 4'b0100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
          64'hFFFF_FFFF_FFFF_FFFD, 4'b0001, MDU_EDGES);
    issue("rem",    2'b10, 1'b1, 4'b0110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 4'b0001, MDU_EDGES);
    issue("divu",   2'b10, 1'b1, 4'b0101, 64'd100, 64'd7, 64'd14, 4'b0000, MDU_EDGES);
    issue("remu",   2'b10, 1'b1, 4'b0111, 64'd100, 64'd7, 64'd2, 4'b0000, MDU_EDGES);
    issue("div_by0",  2'b10, 1'b1, 4'b0100, 64'd42, 64'd0, ONES, 4'b0001, 0);
    issue("remu_by0", 2'b10, 1'b1, 4'b0111, 64'd42, 64'd0, 64'd42, 4'b0000, 0);
    issue("div_ovf",  2'b10, 1'b1, 4'b0100, SMIN, ONES, SMIN, 4'b0001, 0);
    issue("rem_ovf",  2'b10, 1'b1, 4'b0110, SMIN, ONES, 64'd0, 4'b1000, 0);
    wait_idle();

    // Back-to-back ALU throughput
    issue("b2b_0", 2'b00, 1'b0, 4'b0000, 64'd1, 64'd1, 64'd2, 4'b0000, 0);
    acc0 = last_acc;
    issue("b2b_1", 2'b00, 1'b0, 4'b0000, 64'd2, 64'd2, 64'd4, 4'b0000, 0);
    check("b2b_rate_1", 64'(last_acc - acc0), 64'd1);
    acc0 = last_acc;
    issue("b2b_2", 2'b00, 1'b0, 4'b0000, 64'd3, 64'd3, 64'd6, 4'b0000, 0);
    check("b2b_rate_2", 64'(last_acc - acc0), 64'd1);
    wait_idle();

    // Output hold with ready_i low for 3 cycles
    ready_i = 1'b0;
    issue("hold", 2'b00, 1'b0, 4'b0000, 64'h1111, 64'h2222, 64'h3333, 4'b0000, 0);
    @(posedge clk_i); #1;
    check("hold_ready_low", 64'(ready_o), 64'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    ready_i = 1'b1;
    wait_idle();

    // Reset in the middle of a divide
    issue("aborted_divu", 2'b10, 1'b1, 4'b0101, 64'd1000, 64'd3, 64'd333, 4'b0000, MDU_EDGES);
    repeat (10) begin @(posedge clk_i); #1; end
    rst_ni = 1'b0;
    #1;
    sb.delete();
    check("abort_valid", 64'(valid_o), 64'd0);
    check("abort_c", C_o, 64'd0);
    repeat (2) begin @(posedge clk_i); #1; end
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("abort_ready", 64'(ready_o), 64'd1);
    repeat (80) @(posedge clk_i);
    #1;
    issue("post_reset_add", 2'b00, 1'b0, 4'b0000, 64'd40, 64'd2, 64'd42, 4'b0000, 0);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
